hls_mem_arbiter: RTL

HLS_MEM_ARBITER -- requirements
Module: hls_mem_arbiter

---
 rtl/hls_pkg.sv | 17 +
 rtl/hls_sp_ram.sv | 30 +++
 rtl/hls_mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hls_pkg.sv
// Shared constants and FSM encoding for the HLS memory arbiter slice.
package hls_pkg;
    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 10;
    localparam int DW_DEF   = 32;
    localparam int MEM_SIZE = 1024;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of an index into n items; never zero so NREQ=1 still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hls_sp_ram.sv
// Single-port RAM: synchronous read with one-cycle latency, write-enable.
module hls_sp_ram
    import hls_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Read port only updates on loads, so a store leaves the last read visible.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/hls_mem_arbiter.sv
// Round-robin arbiter in front of a single-port RAM, zeroing the RAM after reset.
module hls_mem_arbiter
    import hls_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               busy
);
    localparam int PW = idx_width(NREQ);
    localparam logic [AW-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              init_wr;
    logic              run_en;
    logic [NREQ-1:0]   gnt_vec;
    logic              gnt_any;
    logic [PW-1:0]     gnt_idx;
    int                scan_idx;

    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == CNT_LAST) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Reset gates every access so a held reset cannot touch the RAM.
    always_comb begin
        busy    = 1'b0;
        init_wr = 1'b0;
        run_en  = 1'b0;
        case (state_q)
            ST_INIT: begin
                busy    = 1'b1;
                init_wr = !reset;
            end
            ST_RUN:  run_en = !reset;
            default: busy = 1'b1;
        endcase
    end

    // First requester found scanning ptr, ptr+1, ... wrapping at NREQ.
    always_comb begin
        gnt_vec  = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        if (run_en) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = int'(ptr_q) + k;
                if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
                if (!gnt_any && req[scan_idx]) begin
                    gnt_any           = 1'b1;
                    gnt_vec[scan_idx] = 1'b1;
                    gnt_idx           = PW'(scan_idx);
                end
            end
        end
    end

    assign gnt = gnt_vec;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
        cnt_d = (state_q == ST_INIT) ? cnt_q + AW'(1) : '0;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (init_wr) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = cnt_q;
        end else if (gnt_any) begin
            ram_en    = 1'b1;
            ram_we    = we[gnt_idx];
            ram_addr  = addr[int'(gnt_idx)*AW +: AW];
            ram_wdata = wdata[int'(gnt_idx)*DW +: DW];
        end
    end

    hls_sp_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RAM output is only meaningful in the return cycle; otherwise replay the held word.
    always_comb begin
        rvalid_d = gnt_vec & ~we;
        rdata    = (|rvalid_q) ? ram_rdata : rdata_q;
        rdata_d  = rdata;
    end

    assign rvalid = rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule
